alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the CPU's combinational ALU.
- Adds an encoded opcode, barrel shifts by a variable amount, and iterative multiply and divide.
- Adds a valid/ready handshake on both sides, registered results, and an N/V flag pair alongside C/Z.
- Sits between the register-file read stage and writeback; the control unit stalls on in_ready/out_valid.

---
 rtl/alu_mc.sv | 220 ++++++++++++++++++++++
 tb/tb_alu_mc.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: encoded opcodes, barrel shifts, iterative MUL/DIV, C/Z/N/V flags.
// Latency: 1 cycle for ops 0-8 and 13-15, WIDTH+1 cycles for ops 9-12 (accept to out_valid).
// Backpressure: in_ready only in IDLE; result and flags held in DONE until out_ready.
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             half_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int H = WIDTH / 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [WIDTH-1:0] LO_MASK = {{(WIDTH-H){1'b0}}, {H{1'b1}}};

    logic [1:0]       state;
    logic [SHW-1:0]   cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] hi;       // product high half / partial remainder
    logic [WIDTH-1:0] lo;       // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] opnd;     // multiplicand / divisor

    // sign bit of the active width
    function automatic logic msb_of(input logic [WIDTH-1:0] v, input logic hm);
        return hm ? v[H-1] : v[WIDTH-1];
    endfunction

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    wire accept  = in_valid && in_ready;
    wire is_iter = (op >= 4'd9) && (op <= 4'd12);
    wire is_mul  = (op_q == 4'd9) || (op_q == 4'd10);

    // single-cycle datapath, evaluated on the live inputs at accept time
    logic             hm_eff;
    logic [WIDTH-1:0] mask, am, bm, ax, sc_res;
    logic [SHW-1:0]   s;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH-1:0] wide;
    logic             sa, sb, sc_c, sc_v;

    always_comb begin
        hm_eff = half_mode && (op <= 4'd8);
        mask   = hm_eff ? LO_MASK : '1;
        am     = a & mask;
        bm     = b & mask;
        ax     = hm_eff ? {{(WIDTH-H){a[H-1]}}, a[H-1:0]} : a;
        s      = b[SHW-1:0];
        if (hm_eff)
            s = s % SHW'(H);
        sa     = msb_of(a, hm_eff);
        sb     = msb_of(b, hm_eff);
        sum    = '0;
        wide   = '0;
        sc_res = a;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (op)
            4'd0: begin
                sum    = {1'b0, am} + {1'b0, bm};
                sc_res = sum[WIDTH-1:0] & mask;
                sc_c   = hm_eff ? sum[H] : sum[WIDTH];
                sc_v   = (sa == sb) && (msb_of(sc_res, hm_eff) != sa);
            end
            4'd1: begin
                sum    = {1'b0, am} - {1'b0, bm};
                sc_res = sum[WIDTH-1:0] & mask;
                sc_c   = am < bm;
                sc_v   = (sa != sb) && (msb_of(sc_res, hm_eff) != sa);
            end
            4'd2: sc_res = am & bm;
            4'd3: sc_res = am | bm;
            4'd4: sc_res = am ^ bm;
            4'd5: sc_res = ~am & mask;
            4'd6: begin
                wide   = {{WIDTH{1'b0}}, am} << s;
                sc_res = wide[WIDTH-1:0] & mask;
                sc_c   = hm_eff ? wide[H] : wide[WIDTH];
            end
            4'd7: begin
                // the bit just below the result window is the last one shifted out
                wide   = {am, {WIDTH{1'b0}}} >> s;
                sc_res = wide[2*WIDTH-1:WIDTH];
                sc_c   = wide[WIDTH-1];
            end
            4'd8: begin
                wide   = $signed({ax, {WIDTH{1'b0}}}) >>> s;
                sc_res = wide[2*WIDTH-1:WIDTH] & mask;
                sc_c   = wide[WIDTH-1];
            end
            default: sc_res = a;
        endcase
    end

    // one shift-add or restoring-subtract step per cycle
    logic [WIDTH:0]   msum, shifted;
    logic [WIDTH-1:0] diff, hi_nxt, lo_nxt;

    always_comb begin
        msum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted[WIDTH-1:0] - opnd;
        if (is_mul) begin
            {hi_nxt, lo_nxt} = {msum, lo[WIDTH-1:1]};
        end else if (shifted >= {1'b0, opnd}) begin
            hi_nxt = diff;
            lo_nxt = {lo[WIDTH-2:0], 1'b1};
        end else begin
            hi_nxt = shifted[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], 1'b0};
        end
    end

    // final MUL/DIV result selection, used on the last iteration
    logic [WIDTH-1:0] it_res;
    logic             it_c, it_v;
    wire              div0 = (opnd == '0);

    always_comb begin
        it_res = lo_nxt;
        it_c   = 1'b0;
        it_v   = 1'b0;
        case (op_q)
            4'd9: begin
                it_res = lo_nxt;
                it_c   = |hi_nxt;
                it_v   = |hi_nxt;
            end
            4'd10: it_res = hi_nxt;
            4'd11: begin
                it_res = div0 ? '1 : lo_nxt;
                it_v   = div0;
            end
            default: begin
                it_res = div0 ? a_q : hi_nxt;
                it_v   = div0;
            end
        endcase
    end

    // control FSM and result/flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            result <= '0;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= op;
                        a_q  <= a;
                        if (is_iter) begin
                            cnt   <= SHW'(WIDTH - 1);
                            hi    <= '0;
                            lo    <= (op <= 4'd10) ? b : a;
                            opnd  <= (op <= 4'd10) ? a : b;
                            state <= S_ITER;
                        end else begin
                            result <= sc_res;
                            flag_c <= sc_c;
                            flag_v <= sc_v;
                            flag_z <= (sc_res == '0);
                            flag_n <= msb_of(sc_res, hm_eff);
                            state  <= S_DONE;
                        end
                    end
                end
                S_ITER: begin
                    hi <= hi_nxt;
                    lo <= lo_nxt;
                    if (cnt == '0) begin
                        result <= it_res;
                        flag_c <= it_c;
                        flag_v <= it_v;
                        flag_z <= (it_res == '0);
                        flag_n <= it_res[WIDTH-1];
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, handshake corner cases, random vs model.
// Latency: checks 1-cycle and WIDTH+1-cycle result timing.
// Backpressure: exercises held results under out_ready=0 and reset abort during iteration.
module tb_alu_mc;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic             half_mode;
    logic [WIDTH-1:0] a, b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c, flag_z, flag_n, flag_v;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .half_mode(half_mode), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the opcode definitions.
    // Returns {result[15:0], c, z, n, v}.
    function automatic logic [19:0] model(input logic [3:0] o, input logic hm,
                                          input logic [15:0] av, input logic [15:0] bv);
        int     w, s;
        longint m, x, y, sx, sy, t, r, p, smax, smin;
        logic   c, v, z, n;
        w    = (hm && o <= 4'd8) ? 8 : 16;
        m    = (longint'(1) << w) - 1;
        x    = longint'(av) & m;
        y    = longint'(bv) & m;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sx   = (x > smax) ? x - (longint'(1) << w) : x;
        sy   = (y > smax) ? y - (longint'(1) << w) : y;
        s    = int'(bv[3:0]);
        if (hm && o <= 4'd8) s = s % w;
        p    = longint'(av) * longint'(bv);
        c = 1'b0; v = 1'b0; r = x;
        case (o)
            4'd0: begin
                r = (x + y) & m; c = ((x + y) >> w) != 0;
                t = sx + sy; v = (t > smax) || (t < smin);
            end
            4'd1: begin
                r = (x - y) & m; c = x < y;
                t = sx - sy; v = (t > smax) || (t < smin);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = (~x) & m;
            4'd6: begin
                r = (x << s) & m;
                c = (s == 0) ? 1'b0 : (((x >> (w - s)) & 1) != 0);
            end
            4'd7: begin
                r = x >> s;
                c = (s == 0) ? 1'b0 : (((x >> (s - 1)) & 1) != 0);
            end
            4'd8: begin
                r = (sx >>> s) & m;
                c = (s == 0) ? 1'b0 : (((sx >>> (s - 1)) & 1) != 0);
            end
            4'd9: begin
                r = p & 64'hFFFF; c = (p >> 16) != 0; v = c;
            end
            4'd10: r = p >> 16;
            4'd11: begin
                if (bv == 0) begin r = 64'hFFFF; v = 1'b1; end
                else r = longint'(av) / longint'(bv);
            end
            4'd12: begin
                if (bv == 0) begin r = longint'(av); v = 1'b1; end
                else r = longint'(av) % longint'(bv);
            end
            default: r = longint'(av);
        endcase
        z = (r == 0);
        n = ((r >> (w - 1)) & 1) != 0;
        return {r[15:0], c, z, n, v};
    endfunction

    // Issue one op, wait for the result, hold it for 'hold' cycles, then consume it.
    // Call at posedge+#1.
    task automatic run_op(input logic [3:0] o, input logic hm, input logic [15:0] av,
                          input logic [15:0] bv, input int hold,
                          output logic [15:0] r, output logic [3:0] f,
                          output int lat, output int busy_bad, output int unstable);
        int g;
        op = o; half_mode = hm; a = av; b = bv; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op = 4'($urandom); half_mode = 1'($urandom);
        lat = 1; busy_bad = 0; unstable = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        f = {flag_c, flag_z, flag_n, flag_v};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (result !== r || {flag_c, flag_z, flag_n, flag_v} !== f || !out_valid || in_ready)
                unstable++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        hm;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  cznv;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [15:0] r, r0;
        logic [3:0]  f;
        logic [19:0] exp;
        int          lat, busy_bad, unstable, cnt;
        logic [3:0]  ro;
        logic        rh;
        logic [15:0] ra, rb;

        //         name       op  hm  a         b         res       C Z N V  lat
        vecs[0]  = '{"add_wrap",   4'd0,  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1100, 1};
        vecs[1]  = '{"sub_ovf",    4'd1,  1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1};
        vecs[2]  = '{"sub_half",   4'd1,  1'b1, 16'h1200, 16'h0001, 16'h00FF, 4'b1010, 1};
        vecs[3]  = '{"shl4",       4'd6,  1'b0, 16'h8001, 16'h0004, 16'h0010, 4'b0000, 1};
        vecs[4]  = '{"asr15",      4'd8,  1'b0, 16'h8000, 16'h000F, 16'hFFFF, 4'b0010, 1};
        vecs[5]  = '{"shr0",       4'd7,  1'b0, 16'h0003, 16'h0000, 16'h0003, 4'b0000, 1};
        vecs[6]  = '{"mullo",      4'd9,  1'b0, 16'h1234, 16'h0100, 16'h3400, 4'b1001, 17};
        vecs[7]  = '{"mulhi",      4'd10, 1'b0, 16'h1234, 16'h0100, 16'h0012, 4'b0000, 17};
        vecs[8]  = '{"divu",       4'd11, 1'b0, 16'd100,  16'd7,    16'd14,   4'b0000, 17};
        vecs[9]  = '{"remu",       4'd12, 1'b0, 16'd100,  16'd7,    16'd2,    4'b0000, 17};
        vecs[10] = '{"divu_by0",   4'd11, 1'b0, 16'h00AB, 16'h0000, 16'hFFFF, 4'b0011, 17};
        vecs[11] = '{"remu_by0",   4'd12, 1'b0, 16'h00AB, 16'h0000, 16'h00AB, 4'b0001, 17};
        vecs[12] = '{"op14_pass",  4'd14, 1'b0, 16'hF234, 16'h5555, 16'hF234, 4'b0010, 1};
        vecs[13] = '{"add_half_v", 4'd0,  1'b1, 16'hAB7F, 16'hCD01, 16'h0080, 4'b0011, 1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; half_mode = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_flags",     32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // directed table
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].hm, vecs[i].a, vecs[i].b, 0, r, f, lat, busy_bad, unstable);
            chk({vecs[i].name, "_res"},  32'(r),   32'(vecs[i].res));
            chk({vecs[i].name, "_cznv"}, 32'(f),   32'(vecs[i].cznv));
            chk({vecs[i].name, "_lat"},  32'(lat), 32'(vecs[i].lat));
            chk({vecs[i].name, "_busy"}, 32'(busy_bad), 32'd0);
            chk({vecs[i].name, "_drop"}, 32'(out_valid), 32'd0);
        end

        // backpressure: result held for 5 cycles, no accept while DONE
        op = 4'd0; half_mode = 1'b0; a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 4'd4; a = 16'hFFFF; b = 16'h0F0F;   // producer keeps in_valid high with a new op
        chk("bp_valid_rise", 32'(out_valid), 32'd1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (result !== 16'h3333 || !out_valid || in_ready) cnt++;
        end
        chk("bp_hold", 32'(cnt), 32'd0);
        chk("bp_result", 32'(result), 32'h3333);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        // the held XOR is accepted now
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_res", 32'(result), 32'hF0F0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset during ITER cycle 8 aborts the multiply
        op = 4'd9; half_mode = 1'b0; a = 16'h1234; b = 16'h0100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("abort_busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result",    32'(result),    32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_flags",     32'({flag_c, flag_z, flag_n, flag_v}), 32'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("abort_no_output", 32'(cnt), 32'd0);

        // randomized ops against the reference model
        for (int i = 0; i < 300; i++) begin
            ro = 4'($urandom_range(0, 15));
            rh = 1'($urandom);
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0000 :
                 ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            exp = model(ro, rh, ra, rb);
            run_op(ro, rh, ra, rb, $urandom_range(0, 3), r, f, lat, busy_bad, unstable);
            r0 = exp[19:4];
            chk($sformatf("rnd%0d_op%0d_res", i, ro), 32'(r), 32'(r0));
            chk($sformatf("rnd%0d_op%0d_cznv", i, ro), 32'(f), 32'(exp[3:0]));
            chk($sformatf("rnd%0d_op%0d_lat", i, ro), 32'(lat),
                (ro >= 4'd9 && ro <= 4'd12) ? 32'd17 : 32'd1);
            chk($sformatf("rnd%0d_stable", i), 32'(unstable + busy_bad), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
